drive_mode_ctrl: RTL and testbench
==================================

DRIVE_MODE_CTRL -- requirements
Module: drive_mode_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 1_000_000: consecutive stable cycles (10 ms at 100 MHz) required before a debounced input changes.
REQ-002 Parameter LONG_PRESS_CYCLES, default 100_000_000: debounced hold cycles (1 s) that toggle power.
REQ-003 Parameter BLINK_HALF, default 50_000_000: cycles per half-period of the turn-light blink.
REQ-004 Parameter NUM_MODES, default 3, legal range 1..7: number of mode-select buttons.
REQ-005 Localparam MODE_W = ceil(log2(NUM_MODES+1)), equal to 2 for the default.
REQ-006 clk  in  1  system clock, 100 MHz, single clock domain.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 power_btn  in  1  raw power button, active-high.
REQ-009 mode_btn  in  NUM_MODES  raw mode buttons; bit k selects mode k+1.
REQ-010 turn_left, turn_right  in  1 each  raw turn-request switches, active-high.
REQ-011 power_on  out  1  registered power state; 1 = on.
REQ-012 mode  out  MODE_W  registered mode; 0 = none, k+1 = mode k (default: 1 manual, 2 semi-auto, 3 auto).
REQ-013 turn_left_light, turn_right_light  out  1 each  registered blinking indicator outputs.

Function
REQ-014 Every raw input SHALL pass through a two-flop synchroniser followed by a per-input debouncer.
REQ-015 A debounced value SHALL change only after its synchronised input has differed from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle SHALL clear that input's counter.
REQ-016 The power FSM SHALL have exactly two states, OFF and ON.
REQ-017 The hold counter SHALL count while debounced power_btn = 1 and SHALL clear when it is 0.
REQ-018 The cycle the hold count reaches LONG_PRESS_CYCLES, the FSM SHALL toggle state exactly once, and SHALL NOT toggle again until the button is released (debounced 0) and pressed again.
REQ-019 Hold counter width SHALL be sufficient for LONG_PRESS_CYCLES; the counter SHALL saturate and never wrap.
REQ-020 While ON, a debounced rising edge on mode_btn[k] SHALL set mode = k+1 on the next cycle (1-cycle latency from debounced edge).
REQ-021 Simultaneous rising edges on several mode buttons: the lowest index SHALL win.
REQ-022 A held mode button, or a press of the already-active mode, SHALL cause no change.
REQ-023 While OFF, mode SHALL be 0 and mode-button edges SHALL be ignored; they are not stored.
REQ-024 On the ON->OFF transition, mode SHALL become 0 in the same cycle power_on falls.
REQ-025 On OFF->ON, mode SHALL stay 0 until a mode button is pressed.
REQ-026 Turn lights SHALL be forced to 0 unless power_on = 1 and mode != 0.
REQ-027 When enabled, each light SHALL blink while its debounced request is 1: high for BLINK_HALF cycles, then low for BLINK_HALF cycles, repeating.
REQ-028 Blinking SHALL go high on the cycle after the request is first seen.
REQ-029 Both requests active (hazard): both lights SHALL blink in phase from a single shared blink counter.
REQ-030 Any change in the set of active requests SHALL restart the blink counter with the lights high.
REQ-031 A light whose request drops SHALL go low on the next cycle.
REQ-032 A power toggle coinciding with a mode edge: the power transition SHALL take priority and the mode edge SHALL be discarded.

Reset
REQ-033 Asserting rst SHALL immediately force power_on = 0, mode = 0, both lights = 0, and clear all synchronisers, debouncers, hold and blink counters, with the FSM in OFF.
REQ-034 After rst deasserts, raw inputs already high SHALL be treated as new presses once debounced. A power_btn held through reset SHALL toggle only after a full LONG_PRESS_CYCLES hold.
REQ-035 Reset mid-hold or mid-blink SHALL discard all partial counts.

Verification (bench parameters DEB_CYCLES=4, LONG_PRESS_CYCLES=16, BLINK_HALF=8)
REQ-036 power_btn high for 3 cycles, then low -> no debounced change; power_on stays 0.
REQ-037 power_btn held for 40 cycles -> power_on rises exactly once, 2+4+16 cycles after the press; release then hold again -> power_on = 0 and mode = 0.
REQ-038 ON, mode_btn = 3'b110 rising together -> mode = 2; then mode_btn[0] pressed -> mode = 1; press while OFF -> mode stays 0.
REQ-039 ON, mode = 1, turn_left held -> left light pattern 8 high / 8 low repeating, right light 0; add turn_right -> both lights restart high, in phase.
REQ-040 rst pulsed mid-blink and mid-hold -> all outputs 0 immediately; after release, the held power_btn needs a full 16-cycle hold before toggling.

Source files
------------

// File: rtl/drive_mode_ctrl.sv
// Drive mode controller: debounced power button with long-press on/off toggle,
// mode selection from a bank of buttons, and turn/hazard indicator blinking.
// All raw inputs share one two-flop synchroniser bank and per-bit debouncers.
//
// state  | meaning
// ST_OFF | power off, mode held at 0, lights forced low
// ST_ON  | power on, mode buttons accepted, lights enabled once a mode is set
module drive_mode_ctrl #(
  parameter  int DEB_CYCLES        = 1_000_000,
  parameter  int LONG_PRESS_CYCLES = 100_000_000,
  parameter  int BLINK_HALF        = 50_000_000,
  parameter  int NUM_MODES         = 3,
  localparam int MODE_W            = $clog2(NUM_MODES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 power_btn,
  input  logic [NUM_MODES-1:0] mode_btn,
  input  logic                 turn_left,
  input  logic                 turn_right,
  output logic                 power_on,
  output logic [MODE_W-1:0]    mode,
  output logic                 turn_left_light,
  output logic                 turn_right_light
);

  localparam int NIN = NUM_MODES + 3;
  localparam int DW  = $clog2(DEB_CYCLES + 1);
  localparam int HW  = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int BW  = $clog2(BLINK_HALF + 1);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_PRESS_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  localparam logic [0:0] ST_OFF = 1'b0;
  localparam logic [0:0] ST_ON  = 1'b1;

  // bit 0 power, bits NUM_MODES:1 mode buttons, then left, then right
  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync1_q, sync2_q;
  logic [NIN-1:0] deb_q, deb_d;
  logic [DW-1:0]  deb_cnt_q [NIN];
  logic [DW-1:0]  deb_cnt_d [NIN];

  logic [NUM_MODES-1:0] mode_prev_q;
  logic [NUM_MODES-1:0] rise;
  logic [MODE_W-1:0]    sel;
  logic [MODE_W-1:0]    mode_q, mode_d;
  logic [0:0]           state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 toggle;
  logic                 en;

  logic [1:0]    act, act_prev_q;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [1:0]    light_q, light_d;

  assign raw = {turn_right, turn_left, mode_btn, power_btn};

  // debounce: follow the synchronised input only after DEB_CYCLES straight mismatches
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NIN; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  // long-press detection; saturating so a held button toggles only once
  always_comb begin
    hold_d = hold_q;
    if (!deb_q[0])              hold_d = '0;
    else if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
    toggle = deb_q[0] && (hold_q == HOLD_LAST);
  end

  // power FSM and mode selection; a power toggle swallows any same-cycle mode edge
  always_comb begin
    rise = deb_q[NUM_MODES:1] & ~mode_prev_q;
    sel  = '0;
    for (int k = NUM_MODES - 1; k >= 0; k--) begin
      if (rise[k]) sel = MODE_W'(k + 1);
    end
    state_d = state_q;
    case (state_q)
      ST_OFF:  if (toggle) state_d = ST_ON;
      ST_ON:   if (toggle) state_d = ST_OFF;
      default: state_d = ST_OFF;
    endcase
    mode_d = mode_q;
    if (toggle || state_q == ST_OFF) mode_d = '0;
    else if (|rise)                  mode_d = sel;
    en = (state_d == ST_ON) && (mode_d != '0);
  end

  // shared blink timer, restarted high whenever the set of active lights changes
  always_comb begin
    act         = {deb_q[NUM_MODES+2], deb_q[NUM_MODES+1]} & {2{en}};
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (act != act_prev_q) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    light_d = act & {2{phase_d}};
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      for (int i = 0; i < NIN; i++) deb_cnt_q[i] <= '0;
      mode_prev_q <= '0;
      state_q     <= ST_OFF;
      mode_q      <= '0;
      hold_q      <= '0;
      act_prev_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      light_q     <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      for (int i = 0; i < NIN; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      mode_prev_q <= deb_q[NUM_MODES:1];
      state_q     <= state_d;
      mode_q      <= mode_d;
      hold_q      <= hold_d;
      act_prev_q  <= act;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      light_q     <= light_d;
    end
  end

  assign power_on         = (state_q == ST_ON);
  assign mode             = mode_q;
  assign turn_left_light  = light_q[0];
  assign turn_right_light = light_q[1];

endmodule

// File: tb/tb_drive_mode_ctrl.sv
// Directed bench for drive_mode_ctrl with short debounce/hold/blink periods.
module tb_drive_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       power_btn;
  logic [2:0] mode_btn;
  logic       turn_left, turn_right;
  logic       power_on;
  logic [1:0] mode;
  logic       turn_left_light, turn_right_light;

  int checks   = 0;
  int failures = 0;

  drive_mode_ctrl #(
    .DEB_CYCLES(4), .LONG_PRESS_CYCLES(16), .BLINK_HALF(8), .NUM_MODES(3)
  ) dut (
    .clk(clk), .rst(rst), .power_btn(power_btn), .mode_btn(mode_btn),
    .turn_left(turn_left), .turn_right(turn_right), .power_on(power_on),
    .mode(mode), .turn_left_light(turn_left_light), .turn_right_light(turn_right_light)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; power_btn = 0; mode_btn = '0; turn_left = 0; turn_right = 0;
    repeat (3) tick();
    checks++; if (power_on !== 1'b0) begin failures++; $display("FAIL reset_power got=%b exp=0", power_on); end
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", mode); end
    checks++; if ({turn_left_light, turn_right_light} !== 2'b00) begin failures++; $display("FAIL reset_lights got=%b exp=00", {turn_left_light, turn_right_light}); end
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_glitch();
    int bad = 0;
    power_btn = 1'b1;
    repeat (3) tick();
    power_btn = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (power_on !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL glitch_power got=%0d_high_cycles exp=0", bad); end
  endtask

  task automatic test_power_on();
    int falls = 0;
    power_btn = 1'b1;
    repeat (21) tick();
    checks++; if (power_on !== 1'b0) begin failures++; $display("FAIL power_early got=%b exp=0", power_on); end
    tick();
    checks++; if (power_on !== 1'b1) begin failures++; $display("FAIL power_rise got=%b exp=1", power_on); end
    for (int i = 0; i < 18; i++) begin
      tick();
      if (power_on !== 1'b1) falls++;
    end
    checks++; if (falls != 0) begin failures++; $display("FAIL power_hold_retoggle got=%0d exp=0", falls); end
    power_btn = 1'b0;
    repeat (8) tick();
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL mode_after_on got=%0d exp=0", mode); end
  endtask

  task automatic test_mode();
    mode_btn = 3'b110;
    repeat (6) tick();
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL mode_latency got=%0d exp=0", mode); end
    tick();
    checks++; if (mode !== 2'd2) begin failures++; $display("FAIL mode_simul got=%0d exp=2", mode); end
    mode_btn = 3'b111;
    repeat (7) tick();
    checks++; if (mode !== 2'd1) begin failures++; $display("FAIL mode_btn0 got=%0d exp=1", mode); end
    mode_btn = 3'b000;
    repeat (8) tick();
    checks++; if (mode !== 2'd1) begin failures++; $display("FAIL mode_release got=%0d exp=1", mode); end
    mode_btn = 3'b100;
    repeat (7) tick();
    checks++; if (mode !== 2'd3) begin failures++; $display("FAIL mode_btn2 got=%0d exp=3", mode); end
    mode_btn = 3'b000;
    repeat (8) tick();
    mode_btn = 3'b001;
    repeat (7) tick();
    checks++; if (mode !== 2'd1) begin failures++; $display("FAIL mode_back1 got=%0d exp=1", mode); end
    mode_btn = 3'b000;
    repeat (8) tick();
  endtask

  task automatic test_blink();
    int bad_l = 0, bad_r = 0;
    logic exp;
    turn_left = 1'b1;
    repeat (6) tick();
    checks++; if (turn_left_light !== 1'b0) begin failures++; $display("FAIL blink_start_early got=%b exp=0", turn_left_light); end
    for (int j = 0; j < 32; j++) begin
      tick();
      exp = ((j % 16) < 8);
      if (turn_left_light !== exp) bad_l++;
      if (turn_right_light !== 1'b0) bad_r++;
    end
    checks++; if (bad_l != 0) begin failures++; $display("FAIL blink_left_pattern got=%0d_bad_cycles exp=0", bad_l); end
    checks++; if (bad_r != 0) begin failures++; $display("FAIL blink_right_idle got=%0d_bad_cycles exp=0", bad_r); end
    turn_right = 1'b1;
    repeat (6) tick();
    bad_l = 0; bad_r = 0;
    for (int j = 0; j < 16; j++) begin
      tick();
      exp = (j < 8);
      if (turn_left_light !== exp) bad_l++;
      if (turn_right_light !== exp) bad_r++;
    end
    checks++; if (bad_l != 0) begin failures++; $display("FAIL hazard_left got=%0d_bad_cycles exp=0", bad_l); end
    checks++; if (bad_r != 0) begin failures++; $display("FAIL hazard_right got=%0d_bad_cycles exp=0", bad_r); end
    turn_left = 1'b0;
    repeat (7) tick();
    checks++; if (turn_left_light !== 1'b0) begin failures++; $display("FAIL left_drop got=%b exp=0", turn_left_light); end
  endtask

  task automatic test_power_off();
    power_btn = 1'b1;
    repeat (21) tick();
    checks++; if (power_on !== 1'b1) begin failures++; $display("FAIL off_early got=%b exp=1", power_on); end
    tick();
    checks++; if (power_on !== 1'b0) begin failures++; $display("FAIL off_power got=%b exp=0", power_on); end
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL off_mode got=%0d exp=0", mode); end
    checks++; if (turn_right_light !== 1'b0) begin failures++; $display("FAIL off_light got=%b exp=0", turn_right_light); end
    power_btn = 1'b0;
    repeat (8) tick();
    mode_btn = 3'b010;
    repeat (10) tick();
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL off_mode_press got=%0d exp=0", mode); end
    mode_btn = 3'b000;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid();
    power_btn = 1'b1;
    repeat (22) tick();
    checks++; if (power_on !== 1'b1) begin failures++; $display("FAIL reon_power got=%b exp=1", power_on); end
    power_btn = 1'b0;
    repeat (8) tick();
    mode_btn = 3'b001;
    repeat (7) tick();
    checks++; if (mode !== 2'd1) begin failures++; $display("FAIL reon_mode got=%0d exp=1", mode); end
    checks++; if (turn_right_light !== 1'b1) begin failures++; $display("FAIL reon_light got=%b exp=1", turn_right_light); end
    mode_btn = 3'b000;
    repeat (3) tick();
    power_btn = 1'b1;
    repeat (10) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (power_on !== 1'b0) begin failures++; $display("FAIL rstmid_power got=%b exp=0", power_on); end
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL rstmid_mode got=%0d exp=0", mode); end
    checks++; if (turn_right_light !== 1'b0) begin failures++; $display("FAIL rstmid_light got=%b exp=0", turn_right_light); end
    tick();
    rst = 1'b0;
    repeat (21) tick();
    checks++; if (power_on !== 1'b0) begin failures++; $display("FAIL rstmid_early got=%b exp=0", power_on); end
    tick();
    checks++; if (power_on !== 1'b1) begin failures++; $display("FAIL rstmid_full_hold got=%b exp=1", power_on); end
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL rstmid_mode_after got=%0d exp=0", mode); end
    checks++; if (turn_right_light !== 1'b0) begin failures++; $display("FAIL rstmid_light_after got=%b exp=0", turn_right_light); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_power_on();
    test_mode();
    test_blink();
    test_power_off();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
